// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: access-size codes,
// FSM state type, error-counter width and lane helper functions.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE   = 2'b00;
    localparam logic [1:0] SZ_HALF   = 2'b01;
    localparam logic [1:0] SZ_WORD   = 2'b10;
    localparam int         ERR_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Pull the addressed byte/half out of a RAM word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [1:0]  size,
                                                 input logic        sgn);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res;
        byte_v = word[{lane, 3'b000} +: 8];
        half_v = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: res = {{24{sgn & byte_v[7]}}, byte_v};
            SZ_HALF: res = {{16{sgn & half_v[15]}}, half_v};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] lane,
                                            input logic [1:0] size);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate right-aligned store data across lanes; byte enables pick the target.
    function automatic logic [31:0] store_data(input logic [31:0] wd,
                                               input logic [1:0]  size);
        logic [31:0] res;
        case (size)
            SZ_BYTE: res = {4{wd[7:0]}};
            SZ_HALF: res = {2{wd[15:0]}};
            default: res = wd;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 synchronous single-port RAM with per-byte write enables.
// Contents are intentionally not reset.
module dmem_array #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic [3:0]               be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    // Byte-masked write and registered read of the same word index.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store controller: fixed-latency request/response handshake in front of
// a byte-addressable word RAM, with alignment/range checking and error counting.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [7:0]        err_count
);

    localparam int AW      = $clog2(DEPTH);
    localparam int IDX_TOP = AW + 2;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [1:0]             size_q, size_d;
    logic                   sgn_q, sgn_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   req_ready_q, req_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [31:0]            rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;

    logic                   size_err_s, range_err_s, err_s, access_s;
    logic [3:0]             mem_be_s;
    logic [AW-1:0]          mem_idx_s;
    logic [31:0]            mem_rdata_s;

    // While idle the RAM is addressed from the live request so the read word is
    // ready by the access edge even at LATENCY=1.
    assign mem_idx_s   = (state_q == ST_IDLE) ? req_addr[IDX_TOP-1:2] : addr_q[IDX_TOP-1:2];
    assign range_err_s = (addr_q >> IDX_TOP) != {ADDR_W{1'b0}};
    assign err_s       = size_err_s | range_err_s;
    assign access_s    = (state_q == ST_BUSY) && (cnt_q == 4'd0);
    assign mem_be_s    = (access_s && we_q && !err_s) ? store_be(addr_q[1:0], size_q) : 4'b0000;

    // Size/alignment legality of the latched request.
    always_comb begin
        size_err_s = 1'b0;
        case (size_q)
            SZ_BYTE: size_err_s = 1'b0;
            SZ_HALF: size_err_s = addr_q[0];
            SZ_WORD: size_err_s = (addr_q[1:0] != 2'b00);
            default: size_err_s = 1'b1;
        endcase
    end

    // Next-state and next-output computation for the IDLE/BUSY/RESP sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        err_count_d = err_count_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d        = req_we;
                    size_d      = req_size;
                    sgn_d       = req_signed;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    cnt_d       = 4'(LATENCY - 1);
                    req_ready_d = 1'b0;
                    state_d     = ST_BUSY;
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_s;
                    rsp_rdata_d = (err_s || we_q) ? 32'h0000_0000
                                : load_extract(mem_rdata_s, addr_q[1:0], size_q, sgn_q);
                    if (err_s && (err_count_q != {ERR_CNT_W{1'b1}})) begin
                        err_count_d = err_count_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        err_count_d = err_count_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'h0000_0000;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // Sequencer and response registers; reset aborts any in-flight access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            sgn_q       <= 1'b0;
            addr_q      <= {ADDR_W{1'b0}};
            wdata_q     <= 32'h0000_0000;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
            err_count_q <= {ERR_CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            err_count_q <= err_count_d;
        end
    end

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .be    (mem_be_s),
        .addr  (mem_idx_s),
        .wdata (store_data(wdata_q, size_q)),
        .rdata (mem_rdata_s)
    );

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign err_count = err_count_q;

endmodule
